trace_buffer: RTL and testbench

- Elastic FIFO directly downstream of the trace unit; captures each completed trace record when trace_data_ready pulses.
- The trace unit has no backpressure, so records arriving while the FIFO is full are dropped and counted.
- Presents records to the debug/export consumer through a valid/ready handshake (first-word fall-through).

---
 rtl/ryuki_datatypes.sv | 10 +
 rtl/trace_buffer_if.sv | 20 ++
 rtl/trace_buffer.sv | 103 ++++++++++
 tb/tb_trace_buffer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ryuki_datatypes.sv
// Shared datapath types for the ryuki core; trace_output is the completed-instruction trace record.
package ryuki_datatypes;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] wdata;
    } trace_output;

endpackage

// File: rtl/trace_buffer_if.sv
// Record ingress strobe and valid/ready egress of the trace buffer.
interface trace_buffer_if;
    import ryuki_datatypes::*;

    logic        trace_data_ready;
    trace_output trace_data_i;
    logic        out_valid;
    logic        out_ready;
    trace_output out_data;

    modport master (
        output trace_data_ready, trace_data_i, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  trace_data_ready, trace_data_i, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/trace_buffer.sv
// First-word fall-through FIFO behind the trace unit; records arriving while full are dropped
// and counted, since the trace unit cannot be stalled.
module trace_buffer
    import ryuki_datatypes::*;
#(
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned DROP_CNT_WIDTH  = 16,
    parameter int unsigned ALMOST_FULL_LVL = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    trace_buffer_if.slave                 bus,
    input  logic                          flush,
    input  logic                          clear_overflow,
    output logic [$clog2(DEPTH+1)-1:0]    level,
    output logic                          almost_full,
    output logic                          overflow,
    output logic [DROP_CNT_WIDTH-1:0]     drop_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = $clog2(DEPTH + 1);
    localparam logic [LvlW-1:0] FullLvl = LvlW'(DEPTH);
    localparam logic [LvlW-1:0] AfLvl   = LvlW'(ALMOST_FULL_LVL);

    trace_output mem [DEPTH];

    logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]           level_q, level_d;
    logic                      overflow_q, overflow_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                      valid, full, push, pop, drop;

    always_comb begin
        valid = (level_q != '0);
        full  = (level_q == FullLvl);
        pop   = valid & bus.out_ready;
        // A pop frees the slot in the same cycle, so a full FIFO can still accept.
        push  = bus.trace_data_ready & (!full | pop) & !flush;
        drop  = bus.trace_data_ready & full & !pop & !flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LvlW'(1);
                2'b01:   level_d = level_q - LvlW'(1);
                default: level_d = level_q;
            endcase
        end

        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_overflow) begin
            overflow_d = drop;
            drop_cnt_d = drop ? DROP_CNT_WIDTH'(1) : '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.trace_data_i;
    end

    assign bus.out_valid = valid;
    assign bus.out_data  = mem[rd_ptr_q];
    assign level         = level_q;
    assign almost_full   = (level_q >= AfLvl);
    assign overflow      = overflow_q;
    assign drop_count    = drop_cnt_q;

    a_level_bound: assert property (@(posedge clk) disable iff (rst) level_q <= FullLvl);
    a_head_stable: assert property (@(posedge clk) disable iff (rst)
        (valid && !bus.out_ready && !flush) |=> $stable(bus.out_data));
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer: default instance plus a tiny instance for counter saturation.
module tb_trace_buffer;
    import ryuki_datatypes::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trace_buffer_if bus0 ();
    trace_buffer_if bus1 ();

    logic        flush0, clr0, flush1, clr1;
    logic [4:0]  level0;
    logic [1:0]  level1;
    logic        af0, af1, ovf0, ovf1;
    logic [15:0] dc0;
    logic [1:0]  dc1;

    int checks = 0;
    int errors = 0;

    trace_buffer #(.DEPTH(16), .DROP_CNT_WIDTH(16), .ALMOST_FULL_LVL(12)) dut (
        .clk(clk), .rst(rst), .bus(bus0), .flush(flush0), .clear_overflow(clr0),
        .level(level0), .almost_full(af0), .overflow(ovf0), .drop_count(dc0)
    );

    trace_buffer #(.DEPTH(2), .DROP_CNT_WIDTH(2), .ALMOST_FULL_LVL(2)) dut_small (
        .clk(clk), .rst(rst), .bus(bus1), .flush(flush1), .clear_overflow(clr1),
        .level(level1), .almost_full(af1), .overflow(ovf1), .drop_count(dc1)
    );

    function automatic trace_output rec(input int i);
        trace_output r;
        r.pc    = 32'h1000 + 32'(i) * 4;
        r.insn  = 32'(i) ^ 32'h0BAD_0000;
        r.wdata = ~32'(i);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus0.trace_data_ready = 1'b0; bus0.trace_data_i = '0; bus0.out_ready = 1'b0;
        bus1.trace_data_ready = 1'b0; bus1.trace_data_i = '0; bus1.out_ready = 1'b0;
        flush0 = 1'b0; clr0 = 1'b0; flush1 = 1'b0; clr1 = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_n(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            bus0.trace_data_ready = 1'b1;
            bus0.trace_data_i     = rec(first + i);
            tick();
        end
        bus0.trace_data_ready = 1'b0;
    endtask

    task automatic pop_n(input int n);
        bus0.out_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
        bus0.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        checks++;
        if (level0 !== 5'd0 || bus0.out_valid !== 1'b0 || af0 !== 1'b0 || ovf0 !== 1'b0
            || dc0 !== 16'd0) begin
            errors++;
            $display("FAIL reset: level=%0d valid=%b af=%b ovf=%b dc=%0d, want all 0",
                     level0, bus0.out_valid, af0, ovf0, dc0);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_first_records();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus0.trace_data_ready = 1'b1;
            bus0.trace_data_i     = rec(i);
            tick();
            checks++;
            if (bus0.out_valid !== 1'b1 || bus0.out_data !== rec(0)) begin
                errors++;
                $display("FAIL first_head[%0d]: valid=%b data=%h, want 1 %h",
                         i, bus0.out_valid, bus0.out_data, rec(0));
            end
        end
        bus0.trace_data_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (level0 !== 5'd4 || bus0.out_data !== rec(0)) begin
            errors++;
            $display("FAIL first_hold: level=%0d data=%h, want 4 %h", level0, bus0.out_data, rec(0));
        end
    endtask

    task automatic test_drain_wrap();
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            push_n(100 * pass, 16);
            checks++;
            if (level0 !== 5'd16 || af0 !== 1'b1) begin
                errors++;
                $display("FAIL drain_full[%0d]: level=%0d af=%b, want 16 1", pass, level0, af0);
            end
            bus0.out_ready = 1'b1;
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (bus0.out_valid !== 1'b1 || bus0.out_data !== rec(100 * pass + i)) begin
                    errors++;
                    $display("FAIL drain_order[%0d][%0d]: valid=%b data=%h, want 1 %h",
                             pass, i, bus0.out_valid, bus0.out_data, rec(100 * pass + i));
                end
                tick();
            end
            bus0.out_ready = 1'b0;
            checks++;
            if (level0 !== 5'd0 || bus0.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL drain_empty[%0d]: level=%0d valid=%b, want 0 0",
                         pass, level0, bus0.out_valid);
            end
            // Offset the pointers so the second pass wraps mid-array.
            if (pass == 0) begin
                push_n(50, 5);
                pop_n(5);
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        push_n(0, 16);
        for (int i = 1; i <= 3; i++) begin
            bus0.trace_data_ready = 1'b1;
            bus0.trace_data_i     = rec(200 + i);
            tick();
            checks++;
            if (dc0 !== 16'(i) || ovf0 !== 1'b1 || level0 !== 5'd16) begin
                errors++;
                $display("FAIL drop[%0d]: dc=%0d ovf=%b level=%0d, want %0d 1 16",
                         i, dc0, ovf0, level0, i);
            end
        end
        clr0 = 1'b1;
        tick();
        checks++;
        if (ovf0 !== 1'b1 || dc0 !== 16'd1) begin
            errors++;
            $display("FAIL clear_with_drop: ovf=%b dc=%0d, want 1 1", ovf0, dc0);
        end
        bus0.trace_data_ready = 1'b0;
        tick();
        clr0 = 1'b0;
        checks++;
        if (ovf0 !== 1'b0 || dc0 !== 16'd0) begin
            errors++;
            $display("FAIL clear_alone: ovf=%b dc=%0d, want 0 0", ovf0, dc0);
        end
    endtask

    // Continues from the full FIFO left by test_drop (R0..R15 stored).
    task automatic test_full_pop_push();
        bus0.out_ready        = 1'b1;
        bus0.trace_data_ready = 1'b1;
        bus0.trace_data_i     = rec(99);
        tick();
        bus0.trace_data_ready = 1'b0;
        bus0.out_ready        = 1'b0;
        checks++;
        if (level0 !== 5'd16 || dc0 !== 16'd0 || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_push: level=%0d dc=%0d ovf=%b, want 16 0 0", level0, dc0, ovf0);
        end
        bus0.out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (bus0.out_data !== rec(i == 16 ? 99 : i)) begin
                errors++;
                $display("FAIL full_pop_push_order[%0d]: data=%h, want %h",
                         i, bus0.out_data, rec(i == 16 ? 99 : i));
            end
            tick();
        end
        bus0.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        push_n(0, 18);
        pop_n(11);
        checks++;
        if (level0 !== 5'd5 || dc0 !== 16'd2) begin
            errors++;
            $display("FAIL flush_setup: level=%0d dc=%0d, want 5 2", level0, dc0);
        end
        flush0 = 1'b1;
        bus0.trace_data_ready = 1'b1;
        bus0.trace_data_i     = rec(77);
        tick();
        flush0 = 1'b0;
        bus0.trace_data_ready = 1'b0;
        checks++;
        if (level0 !== 5'd0 || bus0.out_valid !== 1'b0 || dc0 !== 16'd2 || ovf0 !== 1'b1) begin
            errors++;
            $display("FAIL flush: level=%0d valid=%b dc=%0d ovf=%b, want 0 0 2 1",
                     level0, bus0.out_valid, dc0, ovf0);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        push_n(0, 17);
        pop_n(9);
        checks++;
        if (level0 !== 5'd7 || ovf0 !== 1'b1 || dc0 !== 16'd1) begin
            errors++;
            $display("FAIL areset_setup: level=%0d ovf=%b dc=%0d, want 7 1 1", level0, ovf0, dc0);
        end
        bus0.out_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (level0 !== 5'd0 || bus0.out_valid !== 1'b0 || ovf0 !== 1'b0 || dc0 !== 16'd0) begin
            errors++;
            $display("FAIL areset: level=%0d valid=%b ovf=%b dc=%0d, want 0 0 0 0",
                     level0, bus0.out_valid, ovf0, dc0);
        end
        tick();
        rst = 1'b0;
        bus0.out_ready = 1'b0;
    endtask

    task automatic test_almost_full();
        do_reset();
        push_n(0, 11);
        checks++;
        if (level0 !== 5'd11 || af0 !== 1'b0) begin
            errors++;
            $display("FAIL af_11: level=%0d af=%b, want 11 0", level0, af0);
        end
        push_n(11, 1);
        checks++;
        if (level0 !== 5'd12 || af0 !== 1'b1) begin
            errors++;
            $display("FAIL af_12: level=%0d af=%b, want 12 1", level0, af0);
        end
        pop_n(1);
        checks++;
        if (level0 !== 5'd11 || af0 !== 1'b0) begin
            errors++;
            $display("FAIL af_fall: level=%0d af=%b, want 11 0", level0, af0);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        bus1.trace_data_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus1.trace_data_i = rec(300 + i);
            tick();
            // Two fills, then drops count 1,2,3 and hold at all-ones.
            if (i >= 2) begin
                checks++;
                if (dc1 !== 2'((i - 1 > 3) ? 3 : i - 1) || ovf1 !== 1'b1 || level1 !== 2'd2) begin
                    errors++;
                    $display("FAIL saturate[%0d]: dc=%0d ovf=%b level=%0d, want %0d 1 2",
                             i, dc1, ovf1, level1, (i - 1 > 3) ? 3 : i - 1);
                end
            end
        end
        bus1.trace_data_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_records();
        test_drain_wrap();
        test_drop();
        test_full_pop_push();
        test_flush();
        test_async_reset();
        test_almost_full();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
